// File: rtl/bus_xfer_pkg.sv
// Shared types and constants for the burst transfer controller.
package bus_xfer_pkg;

    // Number of arbiter requesters and the width of an encoded requester index.
    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } xfer_state_t;

    // A grant can start a burst only when it is exactly one-hot and agrees
    // with the encoded bus index.
    function automatic logic grant_is_valid(
        input logic [N_REQ-1:0] g,
        input logic [IDX_W-1:0] b
    );
        return $onehot(g) && g[b];
    endfunction

endpackage

// File: rtl/bus_xfer_ctrl_out_reg.sv
// Single-entry valid/ready output register carrying one data word and the
// index of the requester it came from.
module xfer_out_reg
    import bus_xfer_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic [IDX_W-1:0]  i_src,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [IDX_W-1:0]  o_src,
    output logic              o_free
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [IDX_W-1:0]  r_src;

    // Load a new word, or retire the current one when the target takes it;
    // data is left untouched while stalled so the target sees a stable word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_src   <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_src   <= i_src;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    // The slot can accept a word this cycle if it is empty or draining now.
    assign o_free  = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_src   = r_src;

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Burst transfer controller sitting behind a 4-requester arbiter: latches the
// granted requester, moves BURST_LEN words from it to one shared target, and
// pulses done (or abort then done) back to the owner.
module bus_xfer_ctrl
    import bus_xfer_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        grant,
    input  logic [IDX_W-1:0]        bus,
    input  logic [N_REQ*DATA_W-1:0] src_data,
    input  logic [N_REQ-1:0]        src_valid,
    output logic [N_REQ-1:0]        src_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [IDX_W-1:0]        out_src,
    output logic                    busy,
    output logic [N_REQ-1:0]        done,
    output logic                    abort
);

    localparam int                CNT_W     = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_LEN - 1);

    // Reject illegal burst lengths at elaboration time.
    if (BURST_LEN < 1 || BURST_LEN > 256) begin : g_len_check
        $error("bus_xfer_ctrl: BURST_LEN must be in 1..256");
    end

    xfer_state_t       r_state;
    xfer_state_t       w_state_next;
    logic [IDX_W-1:0]  r_owner;
    logic [CNT_W-1:0]  r_beat_cnt;
    logic              r_abort;

    logic              w_start;
    logic              w_in_xfer;
    logic              w_owner_grant;
    logic              w_out_free;
    logic              w_owner_ready;
    logic              w_accept;
    logic              w_last;
    logic              w_loss;
    logic [DATA_W-1:0] w_src_words [N_REQ];
    logic [DATA_W-1:0] w_src_word;

    // Split the flat source bus into per-requester words.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_src_split
        assign w_src_words[gi] = src_data[gi*DATA_W +: DATA_W];
    end

    assign w_src_word    = w_src_words[r_owner];
    assign w_start       = grant_is_valid(grant, bus);
    assign w_in_xfer     = (r_state == ST_XFER);
    assign w_owner_grant = grant[r_owner];

    // Grant loss gates ready in the same cycle, so a beat can never be taken
    // from an owner that has already lost the bus.  A last beat accepted
    // while granted leaves XFER immediately, so a later drop is not an abort.
    assign w_owner_ready = w_in_xfer && w_owner_grant && w_out_free;
    assign w_accept      = w_owner_ready && src_valid[r_owner];
    assign w_last        = w_accept && (r_beat_cnt == LAST_BEAT);
    assign w_loss        = w_in_xfer && !w_owner_grant;

    // Next-state selection for the burst sequencer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_start)            w_state_next = ST_XFER;
            ST_XFER:  if (w_last || w_loss)   w_state_next = ST_DRAIN;
            ST_DRAIN: if (w_out_free)         w_state_next = ST_FIN;
            ST_FIN:                           w_state_next = ST_IDLE;
            default:                          w_state_next = ST_IDLE;
        endcase
    end

    // State register and the abort pulse, which is one cycle long because
    // XFER is left on the same edge the loss is seen.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_abort <= w_loss;
        end
    end

    // Owner latch and beat counter; the counter stops at BURST_LEN because
    // the final accept also moves the FSM out of XFER.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner    <= '0;
            r_beat_cnt <= '0;
        end else if (r_state == ST_IDLE && w_start) begin
            r_owner    <= bus;
            r_beat_cnt <= '0;
        end else if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
        end
    end

    // Per-requester handshake and completion decode.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
        assign src_ready[gi] = w_owner_ready && (r_owner == IDX_W'(gi));
        assign done[gi]      = (r_state == ST_FIN) && (r_owner == IDX_W'(gi));
    end

    xfer_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_accept),
        .i_data  (w_src_word),
        .i_src   (r_owner),
        .i_ready (out_ready),
        .o_valid (out_valid),
        .o_data  (out_data),
        .o_src   (out_src),
        .o_free  (w_out_free)
    );

    assign busy  = (r_state != ST_IDLE);
    assign abort = r_abort;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Scoreboard bench for bus_xfer_ctrl: stimulus pushes expected words, done
// pulses and abort pulses; a negedge monitor pops and compares them.
module tb_bus_xfer_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  grant;
    logic [1:0]  bus;
    logic [31:0] src_data;
    logic [3:0]  src_valid;
    logic [3:0]  src_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_src;
    logic        busy;
    logic [3:0]  done;
    logic        abort;

    bus_xfer_ctrl #(
        .DATA_W    (8),
        .BURST_LEN (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .grant     (grant),
        .bus       (bus),
        .src_data  (src_data),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src   (out_src),
        .busy      (busy),
        .done      (done),
        .abort     (abort)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [1:0] src;
        int         cyc;
    } exp_word_t;

    typedef struct {
        logic [3:0] val;
        int         cyc;
    } exp_done_t;

    exp_word_t word_q[$];
    exp_done_t done_q[$];
    int        abort_q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [7:0] base [4];
    int         idx  [4];
    logic [3:0] acc_flags = 4'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_vec++;
        n_err++;
        $display("FAIL %s: got 0x%0h with nothing expected (cycle %0d)", name, act, cyc);
    endtask

    // Cycle counter: value k during the period following the k-th rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Requester model: each requester always offers base+idx and advances
    // idx once a handshake has completed on the rising edge.
    always @(negedge clk) acc_flags = reset ? 4'b0 : (src_valid & src_ready);

    always @(posedge clk) begin
        #1;
        for (int n = 0; n < 4; n++) if (acc_flags[n]) idx[n]++;
    end

    always_comb begin
        src_data = '0;
        for (int n = 0; n < 4; n++) src_data[n*8 +: 8] = base[n] + 8'(idx[n]);
    end

    // Monitor: compares every delivered word, done pulse and abort pulse
    // against the scoreboard, and checks stall behaviour.
    exp_word_t  mon_w;
    exp_done_t  mon_d;
    int         mon_a;
    logic       held_valid = 1'b0;
    logic [7:0] held_data;

    always @(negedge clk) begin
        if (!reset && held_valid) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(out_data), 32'(held_data));
        end
        held_valid = 1'b0;
        if (out_valid && !out_ready) begin
            held_valid = 1'b1;
            held_data  = out_data;
            check("stall_src_ready", 32'(src_ready), 32'd0);
        end
        if (out_valid && out_ready) begin
            if (word_q.size() == 0) unexpected("extra_word", 32'(out_data));
            else begin
                mon_w = word_q.pop_front();
                $display("word: data=%02h src=%0d cycle=%0d", out_data, out_src, cyc);
                check("out_data", 32'(out_data), 32'(mon_w.data));
                check("out_src", 32'(out_src), 32'(mon_w.src));
                if (mon_w.cyc >= 0) check("word_cycle", cyc, mon_w.cyc);
            end
        end
        if (done != 4'b0) begin
            if (done_q.size() == 0) unexpected("extra_done", 32'(done));
            else begin
                mon_d = done_q.pop_front();
                $display("done: %b cycle=%0d", done, cyc);
                check("done", 32'(done), 32'(mon_d.val));
                if (mon_d.cyc >= 0) check("done_cycle", cyc, mon_d.cyc);
            end
        end
        if (abort) begin
            if (abort_q.size() == 0) unexpected("extra_abort", 32'(abort));
            else begin
                mon_a = abort_q.pop_front();
                $display("abort: cycle=%0d", cyc);
                check("abort_cycle", cyc, mon_a);
            end
        end
    end

    task automatic push_burst(input logic [7:0] b, input logic [1:0] src,
                              input int nbeats, input int first_cyc);
        exp_word_t w;
        for (int i = 0; i < nbeats; i++) begin
            w.data = b + 8'(i);
            w.src  = src;
            w.cyc  = (first_cyc < 0) ? -1 : first_cyc + i;
            word_q.push_back(w);
        end
    endtask

    task automatic push_done(input logic [3:0] v, input int c);
        exp_done_t d;
        d.val = v;
        d.cyc = c;
        done_q.push_back(d);
    endtask

    // Waits at negedges for a done pulse, bounded.
    task automatic wait_done(input string name);
        int k = 0;
        while (k < 60 && done == 4'b0) begin
            @(negedge clk);
            k++;
        end
        if (done == 4'b0) unexpected({name, "_timeout"}, 32'(done));
    endtask

    // Waits until requester n has completed v handshakes; returns at posedge+2.
    task automatic wait_idx(input int n, input int v, input string name);
        int k = 0;
        while (k < 60 && idx[n] < v) begin
            @(posedge clk);
            #2;
            k++;
        end
        if (idx[n] < v) unexpected({name, "_timeout"}, 32'(idx[n]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int t0;
    int c;

    initial begin
        for (int n = 0; n < 4; n++) begin
            base[n] = 8'h00;
            idx[n]  = 0;
        end
        reset     = 1'b1;
        grant     = 4'b0100;
        bus       = 2'd2;
        src_valid = 4'b1111;
        out_ready = 1'b1;
        base[2]   = 8'h20;

        // Reset held two cycles with a valid grant present.
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_src", 32'(out_src), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_abort", 32'(abort), 32'd0);
        check("rst_src_ready", 32'(src_ready), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        t0 = cyc;
        check("start_busy", 32'(busy), 32'd1);
        check("start_src_ready", 32'(src_ready), 32'b0100);
        push_burst(8'h20, 2'd2, 4, t0 + 1);
        push_done(4'b0100, t0 + 5);
        wait_done("rst_burst");
        grant = 4'b0000;

        // Basic burst from requester 0, full throughput.
        @(negedge clk);
        base[0] = 8'hA0;
        idx[0]  = 0;
        grant   = 4'b0001;
        bus     = 2'd0;
        @(posedge clk);
        #1;
        t0 = cyc;
        push_burst(8'hA0, 2'd0, 4, t0 + 1);
        push_done(4'b0001, t0 + 5);
        wait_done("basic");
        grant = 4'b0000;

        // Backpressure: target stalls for three cycles mid-burst.
        @(negedge clk);
        base[3] = 8'h30;
        idx[3]  = 0;
        grant   = 4'b1000;
        bus     = 2'd3;
        push_burst(8'h30, 2'd3, 4, -1);
        push_done(4'b1000, -1);
        wait_idx(3, 2, "bp");
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        out_ready = 1'b1;
        wait_done("bp");
        grant = 4'b0000;

        // Grant loss after two beats; requester 2 is then granted.
        @(negedge clk);
        base[1] = 8'h10;
        idx[1]  = 0;
        base[2] = 8'h40;
        idx[2]  = 0;
        grant   = 4'b0010;
        bus     = 2'd1;
        push_burst(8'h10, 2'd1, 2, -1);
        wait_idx(1, 2, "loss");
        grant = 4'b0100;
        bus   = 2'd2;
        c     = cyc;
        abort_q.push_back(c + 1);
        push_done(4'b0010, c + 2);
        push_burst(8'h40, 2'd2, 4, c + 5);
        push_done(4'b0100, c + 9);
        wait_done("loss_first");
        check("loss_fin_src_ready", 32'(src_ready), 32'd0);
        @(negedge clk);
        wait_done("loss_second");
        grant = 4'b0000;

        // Malformed grants are ignored.
        @(negedge clk);
        grant = 4'b0110;
        bus   = 2'd1;
        repeat (3) begin
            @(negedge clk);
            check("multihot_busy", 32'(busy), 32'd0);
            check("multihot_src_ready", 32'(src_ready), 32'd0);
        end
        grant = 4'b0010;
        bus   = 2'd3;
        repeat (3) begin
            @(negedge clk);
            check("mismatch_busy", 32'(busy), 32'd0);
            check("mismatch_src_ready", 32'(src_ready), 32'd0);
        end
        grant = 4'b0000;

        // Reset after beat 2, then a fresh burst from the same grant.
        @(negedge clk);
        base[0] = 8'h50;
        idx[0]  = 0;
        grant   = 4'b0001;
        bus     = 2'd0;
        push_burst(8'h50, 2'd0, 2, -1);
        wait_idx(0, 2, "mid_rst");
        reset = 1'b1;
        @(posedge clk);
        #2;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        base[0] = 8'h60;
        idx[0]  = 0;
        reset   = 1'b0;
        @(posedge clk);
        #1;
        t0 = cyc;
        push_burst(8'h60, 2'd0, 4, t0 + 1);
        push_done(4'b0001, t0 + 5);
        wait_done("after_rst");
        grant = 4'b0000;

        repeat (5) @(negedge clk);
        check("words_left", 32'(word_q.size()), 32'd0);
        check("dones_left", 32'(done_q.size()), 32'd0);
        check("aborts_left", 32'(abort_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
